// File: rtl/if_axi_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_axi_fetch
// Purpose  : Instruction-fetch AXI4 read master. This block takes the current
//            PC and issues one single-beat read for each PC value. It returns
//            the fetched word to IF/ID. It stalls the PC until the
//            instruction for that PC is available.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ID_W         width of ARID/RID
//   AR_ID        constant ID driven on ARID
//   NOP_INST     word delivered after reset or on an RRESP error
// Ports
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   fetch_en     core allowed to fetch (0 parks the FSM in IDLE)
//   pc_in        current PC, stable while pc_stall_axi=1
//   kill         redirect/flush: discard the in-flight fetch result
//   dm_stall     data-memory stall from the MEM stage
//   inst_out     fetched instruction, valid when pc_stall_axi=0
//   pc_stall_axi 1 = PC and IF must hold
//   fetch_err    sticky flag, set when a non-OKAY RRESP is seen
//   AR*/R*       AXI4 read address / read data channels (single beat)
// ============================================================================
module if_axi_fetch #(
    parameter int unsigned     ID_W     = 4,
    parameter logic [ID_W-1:0] AR_ID    = '0,
    parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic [31:0]     pc_in,
    input  logic            kill,
    input  logic            dm_stall,
    output logic [31:0]     inst_out,
    output logic            pc_stall_axi,
    output logic            fetch_err,
    output logic [ID_W-1:0] ARID,
    output logic [31:0]     ARADDR,
    output logic [3:0]      ARLEN,
    output logic [2:0]      ARSIZE,
    output logic [1:0]      ARBURST,
    output logic            ARVALID,
    input  logic            ARREADY,
    input  logic [ID_W-1:0] RID,
    input  logic [31:0]     RDATA,
    input  logic [1:0]      RRESP,
    input  logic            RLAST,
    input  logic            RVALID,
    output logic            RREADY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    state_e      state_q, state_d;
    logic        drop_q,  drop_d;
    logic [31:0] inst_q,  inst_d;
    logic        err_q,   err_d;

    // A kill counts only while a read is in flight (address or data phase).
    logic        kill_live;
    // The beat being accepted this cycle is discarded if the fetch was killed
    // earlier or is killed in this very cycle.
    logic        discard_beat;

    assign kill_live    = kill && ((state_q == S_ADDR) || (state_q == S_DATA));
    assign discard_beat = drop_q || kill;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
            inst_q  <= NOP_INST;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        inst_d  = inst_q;
        err_d   = err_q;
        ARVALID = 1'b0;
        RREADY  = 1'b0;

        if (kill_live) begin
            drop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (fetch_en) begin
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                // ARVALID stays up until accepted; fetch_en cannot withdraw it.
                ARVALID = 1'b1;
                if (ARREADY) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    if (discard_beat) begin
                        // Stale beat: drop it and refetch from the current PC.
                        drop_d  = 1'b0;
                        state_d = S_ADDR;
                    end else begin
                        if (RRESP == RESP_OKAY) begin
                            inst_d = RDATA;
                        end else begin
                            inst_d = NOP_INST;
                            err_d  = 1'b1;
                        end
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // The PC advances on the edge that leaves DONE.
                if (!dm_stall) begin
                    state_d = fetch_en ? S_ADDR : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc_stall_axi = (state_q != S_DONE) || dm_stall;
    assign inst_out     = inst_q;
    assign fetch_err    = err_q;

    assign ARID    = AR_ID;
    assign ARADDR  = {pc_in[31:2], 2'b00};
    assign ARLEN   = 4'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;

    // Inputs consumed only by protocol checks below.
    logic unused_inputs;
    assign unused_inputs = ^{pc_in[1:0], RLAST, RID};

`ifndef SYNTHESIS
    // Only one read is ever outstanding, so a beat outside DATA is illegal.
    a_rvalid_in_data: assert property (@(posedge clk) disable iff (!rst_n)
        RVALID |-> (state_q == S_DATA));

    a_rid_match: assert property (@(posedge clk) disable iff (!rst_n)
        RVALID |-> (RID == AR_ID));

    a_rlast_single: assert property (@(posedge clk) disable iff (!rst_n)
        RVALID |-> RLAST);

    a_arvalid_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (ARVALID && !ARREADY) |=> (ARVALID && $stable(ARADDR)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_axi_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_axi_fetch
// Purpose  : Randomised bench for if_axi_fetch. It contains a transaction-level
//            AXI slave and PC model, plus a scoreboard of expected
//            instructions that an independent monitor process checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_axi_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en, kill, dm_stall;
    logic [31:0] pc_in;
    logic [31:0] inst_out;
    logic        pc_stall_axi, fetch_err;
    logic [3:0]  ARID, RID;
    logic [31:0] ARADDR, RDATA;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST, RRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    if_axi_fetch #(.ID_W(4), .AR_ID(4'd0), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_in(pc_in),
        .kill(kill), .dm_stall(dm_stall), .inst_out(inst_out),
        .pc_stall_axi(pc_stall_axi), .fetch_err(fetch_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    // Reference model state
    logic [31:0] pc;
    bit          data_pend, killed, err_model, zw;
    int          rdelay, cyc, last_cons, stuck;
    int          ar_pct, kill_pct, dm_pct, fe_pct, max_dly, jump_pct;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    endtask

    // Drive all inputs at the falling edge.
    task automatic drive();
        @(negedge clk);
        if (!data_pend) RVALID = 1'b0;
        if (data_pend && !RVALID) begin
            if (rdelay == 0) begin
                RVALID = 1'b1;
                RDATA  = $urandom;
                RRESP  = ($urandom_range(7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end else begin
                rdelay--;
            end
        end
        ARREADY  = ($urandom_range(99) < ar_pct);
        dm_stall = ($urandom_range(99) < dm_pct);
        fetch_en = ($urandom_range(99) < fe_pct);
        kill     = ($urandom_range(99) < kill_pct);
        // A redirect moves the PC while the killed read waits for its data.
        if (kill && data_pend) pc = $urandom;
        pc_in = pc;
    endtask

    // Just before the rising edge, record the transactions that edge completes.
    task automatic sample();
        exp_t e;
        #4;
        cyc++;
        if (kill && (ARVALID || data_pend)) killed = 1'b1;
        if (ARVALID && ARREADY) begin
            chk("one_outstanding", expq.size(), 0);
            data_pend = 1'b1;
            rdelay    = $urandom_range(max_dly);
        end
        if (RVALID && RREADY) begin
            data_pend = 1'b0;
            if (killed) begin
                killed = 1'b0;
            end else begin
                if (RRESP != 2'b00) err_model = 1'b1;
                e.inst = (RRESP == 2'b00) ? RDATA : NOP;
                e.err  = err_model;
                expq.push_back(e);
            end
        end
        if (!pc_stall_axi) begin
            if (zw && last_cons >= 0) chk("throughput", cyc - last_cons, 3);
            last_cons = cyc;
            pc = ($urandom_range(99) < jump_pct) ? $urandom : pc + 32'd4;
        end
        if (ARVALID || RREADY || !pc_stall_axi) stuck = 0;
        else stuck++;
    endtask

    task automatic cycle();
        drive();
        sample();
        if (stuck > 300) begin
            chk("progress_timeout", stuck, 0);
            finish_sim();
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: check the address channel and consume instructions
    // ------------------------------------------------------------------
    logic        pv_ar, pv_rdy;
    logic [31:0] pv_addr;

    always begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
            pv_ar = 1'b0;
        end else begin
            if (ARVALID) chk("araddr", ARADDR, {pc_in[31:2], 2'b00});
            if (pv_ar && !pv_rdy) begin
                chk("arvalid_hold", ARVALID, 1);
                chk("araddr_hold", ARADDR, pv_addr);
            end
            if (expq.size() == 0) begin
                chk("stall_without_inst", pc_stall_axi, 1);
            end else if (!ARVALID && !RREADY) begin
                chk("inst_out", inst_out, expq[0].inst);
                chk("fetch_err", fetch_err, expq[0].err);
                chk("stall_in_done", pc_stall_axi, dm_stall);
                if (!pc_stall_axi) void'(expq.pop_front());
            end
            pv_ar   = ARVALID;
            pv_rdy  = ARREADY;
            pv_addr = ARADDR;
        end
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; kill = 1'b0; dm_stall = 1'b0;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        RID = 4'd0; RLAST = 1'b1;
        pc = 32'h0; pc_in = pc;
        data_pend = 0; killed = 0; err_model = 0; zw = 0;
        rdelay = 0; cyc = 0; last_cons = -1; stuck = 0;
        ar_pct = 100; kill_pct = 0; dm_pct = 0; fe_pct = 100; max_dly = 0; jump_pct = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_inst", inst_out, NOP);
        chk("rst_err", fetch_err, 0);
        chk("rst_stall", pc_stall_axi, 1);
        chk("arlen", ARLEN, 0);
        chk("arsize", ARSIZE, 3'b010);
        chk("arburst", ARBURST, 2'b01);
        chk("arid", ARID, 0);
        rst_n = 1'b1;

        // Zero-wait slave, sequential PCs: one instruction every 3 cycles.
        zw = 1;
        repeat (30) cycle();
        zw = 0;

        // Randomised phases: slow ARREADY, data latency, kills, MEM stalls.
        for (int p = 0; p < 8; p++) begin
            ar_pct   = $urandom_range(20, 100);
            kill_pct = $urandom_range(0, 15);
            dm_pct   = $urandom_range(0, 60);
            fe_pct   = $urandom_range(60, 100);
            max_dly  = $urandom_range(0, 4);
            jump_pct = 10;
            repeat (400) cycle();
        end

        // Reset asserted in DATA with RVALID pending.
        ar_pct = 100; kill_pct = 0; dm_pct = 0; fe_pct = 100; max_dly = 0;
        for (int g = 0; g < 100 && !data_pend; g++) cycle();
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_arvalid", ARVALID, 0);
        chk("async_rst_rready", RREADY, 0);
        chk("async_rst_inst", inst_out, NOP);
        chk("async_rst_err", fetch_err, 0);
        chk("async_rst_stall", pc_stall_axi, 1);
        expq.delete();
        data_pend = 0; killed = 0; err_model = 0; stuck = 0;
        RVALID = 1'b0;
        pc = 32'h0000_2000; pc_in = pc;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        chk("restart_arvalid", ARVALID, 1);
        chk("restart_addr", ARADDR, 32'h0000_2000);

        // Continue with random traffic after the reset.
        kill_pct = 8; dm_pct = 30; ar_pct = 60; max_dly = 3; jump_pct = 10;
        repeat (400) cycle();

        finish_sim();
    end

endmodule
`default_nettype wire
